// File: rtl/rice_core_lsu.sv
// Load/store unit: one outstanding valid/ready bus request, byte-lane alignment, load extension.
// Optional misaligned-access trap enabled by defining RICE_CORE_LSU_MISALIGN_CHECK_EN.
module rice_core_lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
`ifdef RICE_CORE_LSU_MISALIGN_CHECK_EN
    output logic                     o_misaligned,
    output logic [ADDRESS_WIDTH-1:0] o_misaligned_address,
`endif
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [1:0]               i_access_type,
    input  logic [2:0]               i_access_mode,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0]    i_store_data,
    input  logic [4:0]               i_rd,
    output logic                     o_bus_valid,
    input  logic                     i_bus_ready,
    output logic                     o_bus_write,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [3:0]               o_bus_strobe,
    output logic [DATA_WIDTH-1:0]    o_bus_write_data,
    input  logic                     i_bus_response_valid,
    input  logic [DATA_WIDTH-1:0]    i_bus_read_data,
    output logic                     o_wb_valid,
    output logic [4:0]               o_wb_rd,
    output logic [DATA_WIDTH-1:0]    o_wb_data
);
    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESPONSE} state_t;

    state_t      state_reg;
    logic [1:0]  off_reg;
    logic [2:0]  mode_reg;
    logic [4:0]  rd_reg;

    logic        is_store, is_load, misaligned, issue;
    logic [3:0]  strobe_next;
    logic [31:0] wdata_next, shifted, load_ext;

    assign is_store = (i_access_type == 2'd1);
    assign is_load  = (i_access_type == 2'd2);
    assign o_ready  = (state_reg == IDLE);

    // Mode decode: 000/100 byte, 001/101 half, everything else (incl. undefined) word.
    always_comb begin
        strobe_next = 4'hF;
        wdata_next  = i_store_data;
        case (i_access_mode)
            3'b000, 3'b100: begin
                strobe_next = 4'b0001 << i_address[1:0];
                wdata_next  = {4{i_store_data[7:0]}};
            end
            3'b001, 3'b101: begin
                strobe_next = 4'b0011 << i_address[1:0];
                wdata_next  = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef RICE_CORE_LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (i_access_mode)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = i_address[0];
            default:        misaligned = |i_address[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign issue = i_valid && (is_store || is_load) && !misaligned;

    always_comb begin
        shifted  = i_bus_read_data >> {off_reg, 3'b000};
        load_ext = shifted;
        case (mode_reg)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg        <= IDLE;
            off_reg          <= 2'd0;
            mode_reg         <= 3'd0;
            rd_reg           <= 5'd0;
            o_bus_valid      <= 1'b0;
            o_bus_write      <= 1'b0;
            o_bus_address    <= '0;
            o_bus_strobe     <= 4'd0;
            o_bus_write_data <= '0;
            o_wb_valid       <= 1'b0;
            o_wb_rd          <= 5'd0;
            o_wb_data        <= '0;
`ifdef RICE_CORE_LSU_MISALIGN_CHECK_EN
            o_misaligned         <= 1'b0;
            o_misaligned_address <= '0;
`endif
        end else begin
            o_wb_valid <= 1'b0;
`ifdef RICE_CORE_LSU_MISALIGN_CHECK_EN
            o_misaligned <= 1'b0;
            if (state_reg == IDLE && i_valid && (is_store || is_load) && misaligned) begin
                o_misaligned         <= 1'b1;
                o_misaligned_address <= i_address;
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        off_reg          <= i_address[1:0];
                        mode_reg         <= i_access_mode;
                        rd_reg           <= i_rd;
                        o_bus_valid      <= 1'b1;
                        o_bus_write      <= is_store;
                        o_bus_address    <= {i_address[ADDRESS_WIDTH-1:2], 2'b00};
                        o_bus_strobe     <= is_store ? strobe_next : 4'hF;
                        o_bus_write_data <= wdata_next;
                        state_reg        <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Stores are posted: no response is expected.
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        state_reg   <= o_bus_write ? IDLE : WAIT_RESPONSE;
                    end
                end
                WAIT_RESPONSE: begin
                    if (i_bus_response_valid) begin
                        o_wb_valid <= 1'b1;
                        o_wb_data  <= load_ext;
                        o_wb_rd    <= rd_reg;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
